// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared definitions for the MDU issue controller: op codes, latency classes
// and issue-FSM states.
package mdu_pkg;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MTHI  = 4'd3;
    localparam logic [3:0] OP_MTLO  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_DIV   = 4'd7;
    localparam logic [3:0] OP_DIVU  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;

    typedef enum logic [1:0] {LAT_NONE, LAT_MUL, LAT_DIV} lat_cls_t;

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;

    function automatic logic is_mdu_op(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO, OP_MFHI,
            OP_MFLO, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// Bus between the E-stage issuer (master) and the multiply/divide unit (slave).
interface mdu_issue_ctrl_if;

    logic        start;
    logic [3:0]  xalu_op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        mdu_busy;
    logic [31:0] mdu_out;

    modport master (
        output start, xalu_op, d1, d2,
        input  mdu_busy, mdu_out
    );

    modport slave (
        input  start, xalu_op, d1, d2,
        output mdu_busy, mdu_out
    );

endinterface

// File: rtl/mdu_issue_ctrl_lat_decode.sv
// Maps an MDU op code plus divisor-is-zero flag to its busy latency class
// and the shadow-counter load value.
module mdu_lat_decode
    import mdu_pkg::*;
#(
    parameter int SH_W       = 4,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic [3:0]      op,
    input  logic            rt_zero,
    output lat_cls_t        cls,
    output logic [SH_W-1:0] cnt
);

    always_comb begin
        cls = LAT_NONE;
        cnt = '0;
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU: begin
                cls = LAT_MUL;
                cnt = SH_W'(MUL_CYCLES);
            end
            // A zero divisor never makes the MDU busy.
            OP_DIV, OP_DIVU: begin
                if (!rt_zero) begin
                    cls = LAT_DIV;
                    cnt = SH_W'(DIV_CYCLES);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU issuer: gates Start, stalls while the MDU is occupied, registers
// mfhi/mflo results and cross-checks MDU Busy against a shadow latency counter.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int WAIT_MAX   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_rs,
    input  logic [31:0]      req_rt,
    input  logic             flush,
    mdu_issue_ctrl_if.master mdu,
    output logic             stall,
    output logic             res_valid,
    output logic [31:0]      res_data,
    output logic             err
);

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int SH_W    = ($clog2(MAX_LAT + 1) > 4) ? $clog2(MAX_LAT + 1) : 4;
    localparam int RUN_W   = $clog2(WAIT_MAX + 2);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(WAIT_MAX);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(WAIT_MAX + 1);

    logic [SH_W-1:0]  shadow;
    logic [SH_W-1:0]  lat_cnt;
    lat_cls_t         lat_cls;
    state_t           state;
    state_t           entry_state;
    logic [RUN_W-1:0] busy_run;
    logic             chk_en;
    logic             is_mdu;
    logic             is_read;
    logic             occupied;
    logic             accept;
    logic             rt_zero;

    assign rt_zero  = (req_rt == '0);
    assign is_mdu   = req_valid & ~flush & is_mdu_op(req_op);
    assign is_read  = (req_op == OP_MFHI) || (req_op == OP_MFLO);
    assign occupied = (shadow != '0) | mdu.mdu_busy;
    assign stall    = is_mdu & occupied;
    assign accept   = is_mdu & ~occupied;

    assign mdu.start   = accept & ~is_read;
    assign mdu.xalu_op = req_valid ? req_op : 4'd0;
    assign mdu.d1      = req_rs;
    assign mdu.d2      = req_rt;

    mdu_lat_decode #(
        .SH_W       (SH_W),
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_lat_decode (
        .op      (req_op),
        .rt_zero (rt_zero),
        .cls     (lat_cls),
        .cnt     (lat_cnt)
    );

    always_comb begin
        entry_state = IDLE;
        if (mdu.start) begin
            case (lat_cls)
                LAT_MUL: entry_state = MUL_WAIT;
                LAT_DIV: entry_state = DIV_WAIT;
                default: entry_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
        end else if (mdu.start) begin
            shadow <= lat_cnt;
        end else if (shadow != '0) begin
            shadow <= shadow - 1'b1;
        end
    end

    // A drained wait state can hand straight over to a new issue in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: state <= entry_state;
                MUL_WAIT, DIV_WAIT: begin
                    if (shadow == '0 && !mdu.mdu_busy) begin
                        state <= entry_state;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            res_valid <= accept & is_read;
            if (accept & is_read) begin
                res_data <= mdu.mdu_out;
            end
        end
    end

    // Busy must track the shadow model once anything has issued; long busy runs are a hang.
    always_ff @(posedge clk) begin
        if (reset) begin
            err      <= 1'b0;
            chk_en   <= 1'b0;
            busy_run <= '0;
        end else begin
            if (mdu.start) begin
                chk_en <= 1'b1;
            end
            if (chk_en && (mdu.mdu_busy != (shadow != '0))) begin
                err <= 1'b1;
            end
            if (mdu.mdu_busy) begin
                if (busy_run >= RUN_LIM) begin
                    err <= 1'b1;
                end
                if (busy_run != RUN_SAT) begin
                    busy_run <= busy_run + 1'b1;
                end
            end else begin
                busy_run <= '0;
            end
        end
    end

endmodule
